// File: rtl/mat_switch_pkg.sv
// Shared definitions for the inter-core vector switch and the MatCore switch ports.
// Vector elements travel as IEEE-754 single-precision bit patterns.
package mat_switch_pkg;
    localparam int SWITCH_WIDTH_DEF     = 16;
    localparam int SWITCH_CORE_SIZE_DEF = 4;
    localparam int ELEM_W               = 32;

    typedef logic [SWITCH_WIDTH_DEF-1:0][ELEM_W-1:0] SwitchVec_t;
endpackage

// File: rtl/mat_switch_fifo.sv
// Single (source, destination) pair FIFO with async active-low reset.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module mat_switch_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    logic                        w_do_push, w_do_pop;
    logic [PTR_W-1:0]            w_wr_nxt, w_rd_nxt;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_data_out = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Explicit wrap keeps DEPTH==1 working with a 1-bit pointer.
    assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= w_wr_nxt;
            if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data_in;
    end

    a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_count <= CNT_W'(DEPTH));
endmodule

// File: rtl/mat_switch.sv
// Inter-core vector switch: one FIFO per (src,dst) pair, senders and receivers
// complete independently with one-cycle ok/ready pulses.
module mat_switch
    import mat_switch_pkg::*;
#(
    parameter int SWITCH_WIDTH          = SWITCH_WIDTH_DEF,
    parameter int SWITCH_CORE_SIZE      = SWITCH_CORE_SIZE_DEF,
    parameter int PAIR_DEPTH            = 2,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE),
    parameter int PAIR_CNT_SIZE         = $clog2(PAIR_DEPTH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                                   switch_send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        switch_send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][ELEM_W-1:0]     switch_send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                                   switch_send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                                   switch_recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        switch_recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                                   switch_recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][ELEM_W-1:0]     switch_recv_data,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_SIZE-1:0][PAIR_CNT_SIZE-1:0] pair_count
);
    localparam int N  = SWITCH_CORE_SIZE;
    localparam int VB = SWITCH_WIDTH * ELEM_W;

    logic [N-1:0][N-1:0]          w_push_pair, w_pop_pair, w_full, w_empty;
    logic [N-1:0][N-1:0][VB-1:0]  w_fifo_out;
    logic [N-1:0][VB-1:0]         w_head;
    logic [N-1:0]                 w_push, w_pop;

    logic [N-1:0]                 r_send_ok, r_recv_ready;
    logic [N-1:0][VB-1:0]         r_recv_data;

    genvar gs, gd;
    generate
        for (gs = 0; gs < N; gs++) begin : g_src
            for (gd = 0; gd < N; gd++) begin : g_dst
                mat_switch_fifo #(
                    .WIDTH (VB),
                    .DEPTH (PAIR_DEPTH),
                    .CNT_W (PAIR_CNT_SIZE)
                ) u_fifo (
                    .i_clk      (clock),
                    .i_rst_n    (reset),
                    .i_push     (w_push_pair[gs][gd]),
                    .i_pop      (w_pop_pair[gs][gd]),
                    .i_data_in  (switch_send_data[gs]),
                    .o_data_out (w_fifo_out[gs][gd]),
                    .o_full     (w_full[gs][gd]),
                    .o_empty    (w_empty[gs][gd]),
                    .o_count    (pair_count[gs][gd])
                );
            end
        end
    endgenerate

    // Pop decision uses pre-edge occupancy only, so an empty pair never bypasses.
    always_comb begin
        w_pop      = '0;
        w_pop_pair = '0;
        w_head     = '0;
        for (int d = 0; d < N; d++) begin
            w_head[d] = w_fifo_out[switch_recv_core_idx[d]][d];
            w_pop[d]  = switch_recv_request[d] && !r_recv_ready[d]
                        && !w_empty[switch_recv_core_idx[d]][d];
            w_pop_pair[switch_recv_core_idx[d]][d] = w_pop[d];
        end
    end

    // A full pair still takes a push when its receiver drains it at the same edge.
    always_comb begin
        w_push      = '0;
        w_push_pair = '0;
        for (int s = 0; s < N; s++) begin
            w_push[s] = switch_send_ready[s] && !r_send_ok[s]
                        && (!w_full[s][switch_send_core_idx[s]]
                            || w_pop_pair[s][switch_send_core_idx[s]]);
            w_push_pair[s][switch_send_core_idx[s]] = w_push[s];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_send_ok    <= '0;
            r_recv_ready <= '0;
            r_recv_data  <= '0;
        end else begin
            r_send_ok    <= w_push;
            r_recv_ready <= w_pop;
            for (int d = 0; d < N; d++)
                if (w_pop[d]) r_recv_data[d] <= w_head[d];
        end
    end

    assign switch_send_ok    = r_send_ok;
    assign switch_recv_ready = r_recv_ready;
    assign switch_recv_data  = r_recv_data;
endmodule

// File: tb/tb_mat_switch.sv
// Randomised and directed bench for mat_switch against a queue-based reference model.
module tb_mat_switch;
    import mat_switch_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 2;
    localparam int A = 2;
    localparam int C = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0]             send_ready, send_ok, recv_request, recv_ready;
    logic [N-1:0][A-1:0]      send_idx, recv_idx;
    SwitchVec_t [N-1:0]       send_data, recv_data;
    logic [N-1:0][N-1:0][C-1:0] pair_count;

    mat_switch #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N), .PAIR_DEPTH(D)) dut (
        .clock                (clock),
        .reset                (reset),
        .switch_send_ready    (send_ready),
        .switch_send_core_idx (send_idx),
        .switch_send_data     (send_data),
        .switch_send_ok       (send_ok),
        .switch_recv_request  (recv_request),
        .switch_recv_core_idx (recv_idx),
        .switch_recv_ready    (recv_ready),
        .switch_recv_data     (recv_data),
        .pair_count           (pair_count)
    );

    always #5 clock = ~clock;

    // Reference model: one queue per pair plus the expected output registers.
    SwitchVec_t mq [N][N][$];
    logic [N-1:0] m_ok, m_rdy;
    SwitchVec_t   m_data [N];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f32(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(e + 127), 23'((n << (23 - e)) & 32'h7FFFFF)};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < N; s++)
            for (int d = 0; d < N; d++) mq[s][d].delete();
        m_ok = '0;
        m_rdy = '0;
        for (int d = 0; d < N; d++) m_data[d] = '0;
    endtask

    task automatic model_step();
        bit popf [N];
        bit pushf [N];
        bit pp [N][N];
        if (!reset) begin
            model_clear();
            return;
        end
        for (int s = 0; s < N; s++)
            for (int d = 0; d < N; d++) pp[s][d] = 0;
        for (int d = 0; d < N; d++) begin
            popf[d] = recv_request[d] && !m_rdy[d] && (mq[recv_idx[d]][d].size() > 0);
            if (popf[d]) pp[recv_idx[d]][d] = 1;
        end
        for (int s = 0; s < N; s++)
            pushf[s] = send_ready[s] && !m_ok[s]
                       && (mq[s][send_idx[s]].size() < D || pp[s][send_idx[s]]);
        for (int d = 0; d < N; d++)
            if (popf[d]) m_data[d] = mq[recv_idx[d]][d].pop_front();
        for (int s = 0; s < N; s++)
            if (pushf[s]) mq[s][send_idx[s]].push_back(send_data[s]);
        for (int i = 0; i < N; i++) begin
            m_ok[i]  = pushf[i];
            m_rdy[i] = popf[i];
        end
    endtask

    task automatic compare();
        check("send_ok", 512'(send_ok), 512'(m_ok));
        check("recv_ready", 512'(recv_ready), 512'(m_rdy));
        for (int d = 0; d < N; d++)
            check($sformatf("recv_data[%0d]", d), recv_data[d], m_data[d]);
        for (int s = 0; s < N; s++)
            for (int d = 0; d < N; d++)
                check($sformatf("pair_count[%0d][%0d]", s, d),
                      512'(pair_count[s][d]), 512'(mq[s][d].size()));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic idle();
        send_ready = '0;
        recv_request = '0;
        send_idx = '0;
        recv_idx = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        step();
        reset = 1'b1;
    endtask

    function automatic SwitchVec_t rand_vec();
        SwitchVec_t v;
        for (int i = 0; i < W; i++) v[i] = $urandom;
        return v;
    endfunction

    SwitchVec_t vA, vB, vC, v0;
    int okcnt;

    initial begin
        idle();
        send_data = '0;
        model_clear();
        step();
        check("reset recv_data", 512'(recv_data[0]), 512'(0));
        reset = 1'b1;
        step();

        // Reset mid-transfer
        send_ready[0] = 1; send_idx[0] = 1; send_data[0] = rand_vec();
        step();
        check("rst ok[0]", 512'(send_ok[0]), 512'(1));
        check("rst cnt01=1", 512'(pair_count[0][1]), 512'(1));
        idle();
        do_reset();
        check("rst cnt01=0", 512'(pair_count[0][1]), 512'(0));
        check("rst no ready", 512'(recv_ready), 512'(0));
        recv_request[1] = 1; recv_idx[1] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst no recv", 512'(recv_ready[1]), 512'(0));
        end
        idle();

        // Basic transfer 2 -> 3 with data 1.0..16.0
        for (int i = 0; i < W; i++) send_data[2][i] = f32(i + 1);
        send_ready[2] = 1; send_idx[2] = 3;
        recv_request[3] = 1; recv_idx[3] = 2;
        step();
        check("basic ok[2]", 512'(send_ok[2]), 512'(1));
        check("basic no ready yet", 512'(recv_ready[3]), 512'(0));
        send_ready[2] = 0;
        step();
        check("basic ready[3]", 512'(recv_ready[3]), 512'(1));
        check("basic data[0]=1.0", 512'(recv_data[3][0]), 512'(32'h3F800000));
        check("basic data[15]=16.0", 512'(recv_data[3][15]), 512'(32'h41800000));
        idle();
        step();

        // Full stall, then pop on a full pair with a simultaneous push
        do_reset();
        vA = rand_vec(); vB = rand_vec(); vC = rand_vec();
        send_ready[0] = 1; send_idx[0] = 1; send_data[0] = vA;
        step();
        send_data[0] = vB;
        step();
        step();
        check("stall ok B", 512'(send_ok[0]), 512'(1));
        send_data[0] = vC;
        step();
        step();
        check("stall C no ok", 512'(send_ok[0]), 512'(0));
        check("stall cnt=2", 512'(pair_count[0][1]), 512'(2));
        recv_request[1] = 1; recv_idx[1] = 0;
        step();
        check("full pp ok", 512'(send_ok[0]), 512'(1));
        check("full pp ready", 512'(recv_ready[1]), 512'(1));
        check("full pp data A", recv_data[1], vA);
        check("full pp cnt=2", 512'(pair_count[0][1]), 512'(2));
        send_ready[0] = 0;
        for (int i = 0; i < 6; i++) step();
        check("order last C", recv_data[1], vC);
        check("drained", 512'(pair_count[0][1]), 512'(0));
        idle();

        // All-to-all
        do_reset();
        for (int s = 0; s < N; s++) begin
            send_ready[s] = 1; send_idx[s] = A'((s + 1) % N); send_data[s] = rand_vec();
            recv_request[s] = 1; recv_idx[s] = A'((s + 3) % N);
        end
        v0 = send_data[0];
        step();
        check("a2a ok", 512'(send_ok), 512'(4'hF));
        send_ready = '0;
        step();
        check("a2a ready", 512'(recv_ready), 512'(4'hF));
        check("a2a data 0->1", recv_data[1], v0);
        idle();

        // Lockout: ready held 4 cycles
        do_reset();
        okcnt = 0;
        send_ready[3] = 1; send_idx[3] = 0; send_data[3] = rand_vec();
        for (int i = 0; i < 4; i++) begin
            step();
            okcnt += int'(send_ok[3]);
        end
        check("lockout pushes", 512'(okcnt), 512'(2));
        check("lockout cnt=2", 512'(pair_count[3][0]), 512'(2));
        idle();

        // Randomised traffic
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                send_ready[i]   = ($urandom_range(0, 99) < 60);
                recv_request[i] = ($urandom_range(0, 99) < 55);
                send_idx[i]     = A'($urandom_range(0, N - 1));
                recv_idx[i]     = A'($urandom_range(0, N - 1));
                if ($urandom_range(0, 3) == 0) send_data[i] = rand_vec();
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mat_switch.md
Name: mat_switch

Overview:
- Inter-core vector switch that every MatCore's switch_send_* / switch_recv_* ports connect to; sits directly downstream of each core's send side and upstream of each core's recv side.
- Holds one small FIFO per (source, destination) core pair, so cores exchange SWITCH_WIDTH-element shortreal vectors without a central arbiter.
- Sends and receives are decoupled: a send completes once buffered, and a receive completes once matching data is present.

Parameters:
- SWITCH_WIDTH, 16, elements per transferred vector.
- SWITCH_CORE_SIZE, 4, number of attached cores (N).
- PAIR_DEPTH, 2, FIFO entries per (src,dst) pair; power of two, >=1.
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE), derived core index width.
- PAIR_CNT_SIZE, $clog2(PAIR_DEPTH+1), derived occupancy width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- switch_send_ready  input  [N]  core s requests a send.
- switch_send_core_idx  input  [N][SWITCH_CORE_ADDR_SIZE]  destination core per sender.
- switch_send_data  input  shortreal [N][SWITCH_WIDTH]  vector per sender.
- switch_send_ok  output  [N]  one-cycle send-accepted pulse per sender.
- switch_recv_request  input  [N]  core d requests a receive.
- switch_recv_core_idx  input  [N][SWITCH_CORE_ADDR_SIZE]  source core per receiver.
- switch_recv_ready  output  [N]  one-cycle data-valid pulse per receiver.
- switch_recv_data  output  shortreal [N][SWITCH_WIDTH]  received vector, valid with recv_ready.
- pair_count  output  [N][N][PAIR_CNT_SIZE]  occupancy of FIFO [src][dst], for debug/verification.

Behaviour:
- Reset (reset==0, async): all FIFOs empty (pointers and counts 0); send_ok=0; recv_ready=0; recv_data all 0.0; pair_count all 0. Any in-flight transfer is discarded and no ok/ready pulse is issued for it.
- Send accept, per sender s, decided at clock edge k:
  - Condition: send_ready[s] && !send_ok[s] && FIFO[s][send_core_idx[s]] not full.
  - Action: push send_data[s] at edge k, and send_ok[s]=1 during cycle k+1 only.
  - While send_ok[s] is high, send_ready[s] is ignored (lockout). This prevents a double push while the core drops ready.
- Send stall: if the target FIFO is full, nothing is pushed and send_ok stays 0. The request is re-evaluated every cycle with the current idx and data.
- Receive, per receiver d, decided at edge k:
  - Condition: recv_request[d] && !recv_ready[d] && FIFO[recv_core_idx[d]][d] not empty.
  - Action: pop the head; recv_data[d]=head and recv_ready[d]=1 during cycle k+1.
  - recv_data holds its last value until the next pop. Requests are ignored while recv_ready[d] is high.
- Latency: push to earliest pop is 1 cycle; a vector pushed at edge k can be popped at edge k+1 and reaches recv_data at k+2.
- Simultaneous push and pop on the same pair at one edge:
  - Both are allowed. The count is unchanged, and so is the count when the FIFO is full.
  - When the FIFO is empty, the pop is NOT satisfied that cycle (no bypass); only the push occurs.
- Ordering: strict FIFO per pair. Different pairs are fully independent, so every sender and every receiver can complete in the same cycle.
- Self-send (src==dst) is legal and uses FIFO[s][s].
- Pointers wrap modulo PAIR_DEPTH. count = PAIR_DEPTH means full; 0 means empty.
- Changing idx while stalled is legal; only the idx present at the accepting edge matters.
- No FIFO overflow or underflow is possible by construction; an assertion flags any count outside 0..PAIR_DEPTH.

Decomposition:
- Shared package: SWITCH_WIDTH and SWITCH_CORE_SIZE defaults, and a typedef for the shortreal vector (SwitchVec_t). The same package is used by MatCore's switch ports.
- Sub-module: mat_switch_fifo, a single-pair FIFO (push, pop, data_in, data_out, full, empty, count) with async active-low reset. Instantiated N×N via generate.
- Top level holds the per-sender decode to pair push, the per-receiver mux for pair pop, and the ok/ready/data registers.

Test Plan:
- Reset mid-transfer: core0 sends to core1 (ok seen, pair_count[0][1]=1); assert reset low for one cycle -> pair_count[0][1]=0, no recv_ready. Core1 then requests from core0 -> no recv_ready for 5 cycles.
- Basic transfer: core2 sends {1.0..16.0} to core3 at edge 1 -> send_ok[2] high in cycle 2. Core3 requesting from core2 -> recv_ready[3] in cycle 3 with data {1.0..16.0}.
- Full stall: core0 sends 3 vectors (A, B, C) to core1 with no receive and PAIR_DEPTH=2 -> ok for A and B only; C stalls with pair_count[0][1]=2. Core1 pops once -> C is accepted the next eligible cycle, and pops return A, B, C in order.
- Simultaneous push+pop on a full pair: count stays 2, send_ok and recv_ready both pulse, and FIFO order is preserved.
- All-to-all: every core sends to (s+1)%4 in the same cycle and every core receives from (d+3)%4 -> all four ok pulses arrive together and all four recv_ready pulses arrive together with matching data.
- Lockout: send_ready held high for 4 cycles with the same data to an empty pair -> exactly 2 pushes (ok at cycles 2 and 4), pair_count=2.
